vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// A clk divider produces the pixel enable; horizontal/vertical counters
// run free from it and every registered output is decoded from the
// counter values being loaded, so all outputs line up on the same clk.
// Optional build macro: VGA_TIMING_LINEREQ_EN adds the line_req output
// (one-clk DMA prefetch request at hsync start of a line preceding a
// visible line).
module vga_timing_gen #(
  parameter int CLKDIV = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_ce,
  output logic        hsync,
  output logic        vsync,
  output logic        vid_ena,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        newline,
  output logic        newframe
`ifdef VGA_TIMING_LINEREQ_EN
  ,
  output logic        line_req
`endif
);

  localparam int HTOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [10:0] H_LAST     = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(VTOTAL - 1);
  localparam logic [10:0] H_VIS_C    = 11'(H_VIS);
  localparam logic [10:0] V_VIS_C    = 11'(V_VIS);
  localparam logic [10:0] HS_START   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_reg;
  logic [10:0]      hcount_reg;
  logic [10:0]      vcount_reg;
  logic [10:0]      hcount_next;
  logic [10:0]      vcount_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             vid_ena_next;

  // Pixel enable straight from the divider; reset forces it low at once.
  // With CLKDIV=1 the divider is stuck at DIV_LAST so pix_ce stays high.
  assign pix_ce = !reset && (div_reg == DIV_LAST);

  // Clock divider 0..CLKDIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Next counter values and the output decode taken from them.
  always_comb begin
    hcount_next = (hcount_reg == H_LAST) ? 11'd0 : hcount_reg + 11'd1;
    vcount_next = vcount_reg;
    if (hcount_reg == H_LAST) begin
      vcount_next = (vcount_reg == V_LAST) ? 11'd0 : vcount_reg + 11'd1;
    end
    vid_ena_next = (hcount_next < H_VIS_C) && (vcount_next < V_VIS_C);
    hsync_next   = ((hcount_next >= HS_START) && (hcount_next < HS_END)) ? HS_POL : !HS_POL;
    vsync_next   = ((vcount_next >= VS_START) && (vcount_next < VS_END)) ? VS_POL : !VS_POL;
  end

  // Free-running raster counters; reset parks them on the last pixel so
  // the first pixel enable after release wraps to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_reg <= H_LAST;
      vcount_reg <= V_LAST;
    end else if (pix_ce) begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
    end
  end

  // Level outputs, reloaded only on pixel-enable cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync   <= !HS_POL;
      vsync   <= !VS_POL;
      vid_ena <= 1'b0;
      xpos    <= 11'd0;
      ypos    <= 11'd0;
    end else if (pix_ce) begin
      hsync   <= hsync_next;
      vsync   <= vsync_next;
      vid_ena <= vid_ena_next;
      xpos    <= hcount_next;
      ypos    <= vcount_next;
    end
  end

  // Single-clk line and frame strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newline  <= 1'b0;
      newframe <= 1'b0;
    end else if (pix_ce) begin
      newline  <= (hcount_next == 11'd0);
      newframe <= (hcount_next == 11'd0) && (vcount_next == 11'd0);
    end else begin
      newline  <= 1'b0;
      newframe <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LINEREQ_EN
  logic line_req_next;

  // Request the next line's data at hsync start, but only when the line
  // after the current one is visible (including the wrap into line 0).
  always_comb begin
    line_req_next = (hcount_next == HS_START) &&
                    ((vcount_reg < V_VIS_C - 11'd1) || (vcount_reg == V_LAST));
  end

  // Single-clk prefetch strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_req <= 1'b0;
    end else if (pix_ce) begin
      line_req <= line_req_next;
    end else begin
      line_req <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen with a shrunken raster so whole frames fit
// in a short run. A reference model computes every output from the number
// of clk edges since reset release; expectations are queued on each edge
// and popped/compared at the following falling edge.
module tb_vga_timing_gen;

  localparam int CD     = 3;
  localparam int H_VIS  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 2;
  localparam int V_VIS  = 6;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;
  localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic        vid_ena;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        newline;
    logic        newframe;
    logic        line_req;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce, hsync, vsync, vid_ena, newline, newframe;
  logic [10:0] xpos, ypos;
`ifdef VGA_TIMING_LINEREQ_EN
  logic        line_req;
`endif

  obs_t q[$];
  int   e = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLKDIV(CD), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
    .vid_ena(vid_ena), .xpos(xpos), .ypos(ypos), .newline(newline),
    .newframe(newframe)
`ifdef VGA_TIMING_LINEREQ_EN
    , .line_req(line_req)
`endif
  );

  // Reference: outputs after e_in clk edges since reset release.
  function automatic obs_t model(int e_in, logic rst_in);
    obs_t r;
    int p, pix, x, y;
    bit strobe;
    r = '0;
    r.hsync = !HS_POL;
    r.vsync = !VS_POL;
    if (rst_in) return r;
    r.pix_ce = ((e_in % CD) == CD - 1);
    p = e_in / CD;
    if (p < 1) return r;
    pix = p - 1;
    x = pix % HT;
    y = (pix / HT) % VT;
    strobe = ((e_in % CD) == 0);
    r.xpos     = 11'(x);
    r.ypos     = 11'(y);
    r.vid_ena  = (x < H_VIS) && (y < V_VIS);
    r.hsync    = (x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    r.vsync    = (y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    r.newline  = strobe && (x == 0);
    r.newframe = strobe && (x == 0) && (y == 0);
`ifdef VGA_TIMING_LINEREQ_EN
    r.line_req = strobe && (x == H_VIS + H_FP) && ((y + 1 < V_VIS) || (y == VT - 1));
`endif
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.pix_ce   = pix_ce;
    r.hsync    = hsync;
    r.vsync    = vsync;
    r.vid_ena  = vid_ena;
    r.xpos     = xpos;
    r.ypos     = ypos;
    r.newline  = newline;
    r.newframe = newframe;
`ifdef VGA_TIMING_LINEREQ_EN
    r.line_req = line_req;
`else
    r.line_req = 1'b0;
`endif
    return r;
  endfunction

  // One clk: push the expectation at the edge, return at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) e++;
    q.push_back(model(e, reset));
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 10; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
      else passed++;
    end
    reset = 1'b0;
    e = 0;
    for (int i = 0; i < 2 * CD; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL reset_release e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
      if (e == CD) begin
        checks++;
        if (!(got.newframe === 1'b1 && got.newline === 1'b1 && got.vid_ena === 1'b1 &&
              got.xpos === 11'd0 && got.ypos === 11'd0))
          $display("FAIL first_pixel nf=%b nl=%b ve=%b x=%0d y=%0d required 1 1 1 0 0",
                   got.newframe, got.newline, got.vid_ena, got.xpos, got.ypos);
        else passed++;
      end
    end
    $display("test_reset: first pixel after release at e=%0d", CD);
  endtask

  task automatic test_line();
    obs_t got, exp;
    int hs_low = 0, nl_last = -1, nl_period = -1;
    for (int i = 0; i < 2 * HT * CD; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL line e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
      if (i < HT * CD && got.pix_ce && got.hsync == HS_POL) hs_low++;
      if (got.newline) begin
        if (nl_last >= 0) nl_period = e - nl_last;
        nl_last = e;
      end
    end
    checks++;
    if (hs_low != H_SYNC) $display("FAIL hsync_width got=%0d required=%0d", hs_low, H_SYNC);
    else passed++;
    checks++;
    if (nl_period != HT * CD) $display("FAIL newline_period got=%0d required=%0d", nl_period, HT * CD);
    else passed++;
    $display("test_line: hsync pixels=%0d newline period=%0d", hs_low, nl_period);
  endtask

  task automatic test_frame();
    obs_t got, exp;
    int ve_cnt = 0, vs_low = 0, nf_cnt = 0, nf_last = -1, nf_period = -1, lr_cnt = 0;
    for (int i = 0; i < 2 * HT * VT * CD; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL frame e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
      if (got.pix_ce && got.vid_ena) ve_cnt++;
      if (got.pix_ce && got.vsync == VS_POL) vs_low++;
      if (got.line_req) lr_cnt++;
      if (got.newframe) begin
        nf_cnt++;
        if (nf_last >= 0) nf_period = e - nf_last;
        nf_last = e;
      end
    end
    checks++;
    if (ve_cnt != 2 * H_VIS * V_VIS) $display("FAIL vid_ena_count got=%0d required=%0d", ve_cnt, 2 * H_VIS * V_VIS);
    else passed++;
    checks++;
    if (vs_low != 2 * V_SYNC * HT) $display("FAIL vsync_width got=%0d required=%0d", vs_low, 2 * V_SYNC * HT);
    else passed++;
    checks++;
    if (nf_cnt != 2 || nf_period != HT * VT * CD)
      $display("FAIL newframe_period got=%0d/%0d required=2/%0d", nf_cnt, nf_period, HT * VT * CD);
    else passed++;
`ifdef VGA_TIMING_LINEREQ_EN
    checks++;
    if (lr_cnt != 2 * V_VIS) $display("FAIL line_req_count got=%0d required=%0d", lr_cnt, 2 * V_VIS);
    else passed++;
`endif
    $display("test_frame: vid_ena=%0d vsync=%0d newframes=%0d line_req=%0d", ve_cnt, vs_low, nf_cnt, lr_cnt);
  endtask

  task automatic test_wrap();
    obs_t got, exp;
    int  budget = HT * VT * CD + 10;
    bit  found = 0;
    int  nf_cnt = 0;
    while (budget > 0 && !found) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL pre_wrap e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
      if (exp.pix_ce && exp.xpos == 11'(HT - 1) && exp.ypos == 11'(VT - 1)) found = 1;
      budget--;
    end
    checks++;
    if (!found) $display("FAIL wrap_timeout got=not_reached required=reached");
    else passed++;
    step();
    got = sample();
    exp = q.pop_front();
    checks++;
    if (!(got.xpos === 11'd0 && got.ypos === 11'd0 && got.newline === 1'b1 && got.newframe === 1'b1))
      $display("FAIL wrap x=%0d y=%0d nl=%b nf=%b required 0 0 1 1", got.xpos, got.ypos, got.newline, got.newframe);
    else passed++;
    for (int i = 1; i < HT * VT * CD; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      if (got.newframe) nf_cnt++;
    end
    checks++;
    if (nf_cnt != 0) $display("FAIL extra_newframe got=%0d required=0", nf_cnt);
    else passed++;
    $display("test_wrap: wrapped to (0,0) with newline+newframe");
  endtask

  task automatic test_mid_reset();
    obs_t got, exp;
    int  budget = 2 * HT * CD;
    bit  found = 0;
    while (budget > 0 && !found) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL pre_reset e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
      if (exp.xpos == 11'(H_VIS + H_FP + 1) && exp.hsync == HS_POL) found = 1;
      budget--;
    end
    checks++;
    if (!found || hsync !== HS_POL) $display("FAIL in_hsync found=%0d hsync=%b required 1 %b", found, hsync, HS_POL);
    else passed++;
    reset = 1'b1;
    e = 0;
    #1;
    got = sample();
    exp = model(0, 1'b1);
    checks++;
    if (got !== exp) $display("FAIL async_reset got=%h exp=%h", got, exp);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
      else passed++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3 * CD; i++) begin
      step();
      got = sample();
      exp = q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL restart e=%0d got=%h exp=%h", e, got, exp);
      else passed++;
    end
    $display("test_mid_reset: reset at x=%0d, restart checked", H_VIS + H_FP + 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
